serial_add_host: RTL and testbench

SERIAL_ADD_HOST -- requirements
Module: serial_add_host

---
 rtl/serial_add_host_if.sv | 28 ++
 rtl/serial_add_host.sv | 110 +++++++++++
 tb/tb_serial_add_host.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_host_if.sv
// Host-side handshake and serial-adder link for serial_add_host.
interface serial_add_host_if #(
   parameter int unsigned N = 4
);
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         ready;
   logic         ser_rst;
   logic         ser_a;
   logic         ser_b;
   logic         ser_f;
   logic         ser_cout;
   logic [N:0]   sum;
   logic         done;

   // Environment side: issues requests and models the serial adder.
   modport master (
      output start, a, b, ser_f, ser_cout,
      input  ready, ser_rst, ser_a, ser_b, sum, done
   );

   // Host controller side.
   modport slave (
      input  start, a, b, ser_f, ser_cout,
      output ready, ser_rst, ser_a, ser_b, sum, done
   );
endinterface

// File: rtl/serial_add_host.sv
// Sequences an external Mealy serial adder over N operand bits, LSB first,
// and assembles the N+1-bit unsigned sum. Every output is registered and
// computed one cycle ahead from the next state.
module serial_add_host #(
   parameter int unsigned N = 4
) (
   input  logic            clk,
   input  logic            rst,
   serial_add_host_if.slave bus
);
   localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, CLR, SHIFT, DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  a_sh_q, a_sh_d;
   logic [N-1:0]  b_sh_q, b_sh_d;
   logic [N:0]    sum_q, sum_d;
   logic          ready_q, ready_d;
   logic          ser_rst_q, ser_rst_d;
   logic          ser_a_q, ser_a_d;
   logic          ser_b_q, ser_b_d;
   logic          done_q, done_d;
   logic          last_bit;

   assign last_bit = (cnt_q == CW'(N - 1));

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = CLR;
         CLR:     state_d = SHIFT;
         SHIFT:   if (last_bit) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and look-ahead output values for the next cycle.
   always_comb begin
      a_sh_d = a_sh_q;
      b_sh_d = b_sh_q;
      cnt_d  = cnt_q;
      sum_d  = sum_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_sh_d = bus.a;
               b_sh_d = bus.b;
            end
         end
         CLR: cnt_d = '0;
         SHIFT: begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            if (!last_bit) cnt_d = cnt_q + CW'(1);
            for (int unsigned i = 0; i < N; i++) begin
               if (cnt_q == CW'(i)) sum_d[i] = bus.ser_f;
            end
            if (last_bit) sum_d[N] = bus.ser_cout;
         end
         default: ;
      endcase
      ready_d   = (state_d == IDLE);
      ser_rst_d = (state_d == CLR);
      ser_a_d   = (state_d == SHIFT) && a_sh_d[0];
      ser_b_d   = (state_d == SHIFT) && b_sh_d[0];
      done_d    = (state_d == DONE);
   end

   // Datapath and output registers; reset discards any partial result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         a_sh_q    <= '0;
         b_sh_q    <= '0;
         sum_q     <= '0;
         ready_q   <= 1'b1;
         ser_rst_q <= 1'b1;
         ser_a_q   <= 1'b0;
         ser_b_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         a_sh_q    <= a_sh_d;
         b_sh_q    <= b_sh_d;
         sum_q     <= sum_d;
         ready_q   <= ready_d;
         ser_rst_q <= ser_rst_d;
         ser_a_q   <= ser_a_d;
         ser_b_q   <= ser_b_d;
         done_q    <= done_d;
      end
   end

   assign bus.ready   = ready_q;
   assign bus.ser_rst = ser_rst_q;
   assign bus.ser_a   = ser_a_q;
   assign bus.ser_b   = ser_b_q;
   assign bus.sum     = sum_q;
   assign bus.done    = done_q;
endmodule

// File: tb/tb_serial_add_host.sv
// Directed bench for serial_add_host with a behavioural Mealy serial adder.
module tb_serial_add_host;
   localparam int unsigned N = 4;
   localparam int LAT = N + 2;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;
   int   cyc;
   logic carry;

   serial_add_host_if #(.N(N)) bus_if ();

   serial_add_host #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Mealy serial adder: carry cleared while ser_rst is high.
   always @(posedge clk) begin
      if (bus_if.ser_rst) carry <= 1'b0;
      else                carry <= bus_if.ser_cout;
   end
   assign bus_if.ser_f    = bus_if.ser_a ^ bus_if.ser_b ^ carry;
   assign bus_if.ser_cout = (bus_if.ser_a & bus_if.ser_b) | (carry & (bus_if.ser_a ^ bus_if.ser_b));

   // Issue one start pulse and wait (bounded) for done; lat = -1 on timeout.
   task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv,
                         output logic [N:0] s, output int lat,
                         output logic rdy, output int t_done);
      @(negedge clk);
      rdy = bus_if.ready;
      bus_if.a = av;
      bus_if.b = bv;
      bus_if.start = 1'b1;
      @(posedge clk);
      #1 bus_if.start = 1'b0;
      lat = -1;
      t_done = -1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (bus_if.done === 1'b1) begin
            lat = c;
            t_done = cyc;
            break;
         end
      end
      s = bus_if.sum;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus_if.start = 1'b0;
      bus_if.a = '0;
      bus_if.b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (bus_if.ready !== 1'b1 || bus_if.done !== 1'b0 || bus_if.sum !== 5'd0) begin
         n_err++;
         $display("FAIL reset_outs ready=%b done=%b sum=%0d exp ready=1 done=0 sum=0",
                  bus_if.ready, bus_if.done, bus_if.sum);
      end
      n_vec++;
      if (bus_if.ser_rst !== 1'b1 || bus_if.ser_a !== 1'b0 || bus_if.ser_b !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ser ser_rst=%b ser_a=%b ser_b=%b exp 1 0 0",
                  bus_if.ser_rst, bus_if.ser_a, bus_if.ser_b);
      end
      rst = 1'b1;
      @(negedge clk);
      n_vec++;
      if (bus_if.ser_rst !== 1'b0 || bus_if.ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_release ser_rst=%b ready=%b exp 0 1", bus_if.ser_rst, bus_if.ready);
      end
   endtask

   task automatic test_basic();
      logic [N-1:0] av;
      logic [N-1:0] bv;
      av = 4'd3;
      bv = 4'd5;
      @(negedge clk);
      bus_if.a = av;
      bus_if.b = bv;
      bus_if.start = 1'b1;
      @(posedge clk);
      #1 bus_if.start = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         n_vec++;
         if (bus_if.done !== 1'(c == 6)) begin
            n_err++;
            $display("FAIL basic_done cycle %0d got %b exp %b", c, bus_if.done, c == 6);
         end
         if (c == 1) begin
            n_vec++;
            if (bus_if.ser_rst !== 1'b1 || bus_if.ready !== 1'b0) begin
               n_err++;
               $display("FAIL basic_clr ser_rst=%b ready=%b exp 1 0", bus_if.ser_rst, bus_if.ready);
            end
         end
         if (c >= 2 && c <= 5) begin
            n_vec++;
            if (bus_if.ser_a !== av[c-2] || bus_if.ser_b !== bv[c-2] || bus_if.ser_rst !== 1'b0) begin
               n_err++;
               $display("FAIL basic_bits cycle %0d ser_a=%b ser_b=%b ser_rst=%b exp %b %b 0",
                        c, bus_if.ser_a, bus_if.ser_b, bus_if.ser_rst, av[c-2], bv[c-2]);
            end
         end
         if (c == 6) begin
            n_vec++;
            if (bus_if.sum !== 5'd8) begin
               n_err++;
               $display("FAIL basic_sum got %0d exp 8", bus_if.sum);
            end
         end
         if (c == 7) begin
            n_vec++;
            if (bus_if.ready !== 1'b1 || bus_if.ser_a !== 1'b0 || bus_if.sum !== 5'd8) begin
               n_err++;
               $display("FAIL basic_idle ready=%b ser_a=%b sum=%0d exp 1 0 8",
                        bus_if.ready, bus_if.ser_a, bus_if.sum);
            end
         end
      end
   endtask

   task automatic test_corners();
      logic [N:0] s;
      int lat;
      int t;
      logic rdy;
      run_op(4'd15, 4'd15, s, lat, rdy, t);
      n_vec++;
      if (s !== 5'd30 || lat != LAT) begin
         n_err++;
         $display("FAIL corner_max sum=%0d lat=%0d exp 30 %0d", s, lat, LAT);
      end
      run_op(4'd0, 4'd0, s, lat, rdy, t);
      n_vec++;
      if (s !== 5'd0 || lat != LAT) begin
         n_err++;
         $display("FAIL corner_zero sum=%0d lat=%0d exp 0 %0d", s, lat, LAT);
      end
   endtask

   task automatic test_exhaustive();
      logic [N:0] s;
      logic [N:0] exp_s;
      int lat;
      int t;
      logic rdy;
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            exp_s = 5'(i) + 5'(j);
            run_op(4'(i), 4'(j), s, lat, rdy, t);
            n_vec++;
            if (s !== exp_s || lat != LAT) begin
               n_err++;
               $display("FAIL exh_%0d_%0d sum=%0d lat=%0d exp %0d %0d", i, j, s, lat, exp_s, LAT);
            end
            @(negedge clk);
            n_vec++;
            if (bus_if.done !== 1'b0) begin
               n_err++;
               $display("FAIL exh_pulse_%0d_%0d done=%b exp 0", i, j, bus_if.done);
            end
         end
      end
   endtask

   task automatic test_hold_start();
      int ndone;
      ndone = 0;
      @(negedge clk);
      bus_if.a = 4'd2;
      bus_if.b = 4'd3;
      bus_if.start = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 2) begin
            bus_if.a = 4'd15;
            bus_if.b = 4'd15;
         end
         if (c == 6) bus_if.start = 1'b0;
         if (bus_if.done === 1'b1) ndone++;
         if (c == 6) begin
            n_vec++;
            if (bus_if.done !== 1'b1 || bus_if.sum !== 5'd5) begin
               n_err++;
               $display("FAIL hold_sum done=%b sum=%0d exp 1 5", bus_if.done, bus_if.sum);
            end
         end
      end
      n_vec++;
      if (ndone != 1) begin
         n_err++;
         $display("FAIL hold_count dones=%0d exp 1", ndone);
      end
   endtask

   task automatic test_reset_mid();
      logic [N:0] s;
      int lat;
      int t;
      logic rdy;
      int ndone;
      ndone = 0;
      @(negedge clk);
      bus_if.a = 4'd1;
      bus_if.b = 4'd2;
      bus_if.start = 1'b1;
      @(posedge clk);
      #1 bus_if.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      n_vec++;
      if (bus_if.ready !== 1'b1 || bus_if.sum !== 5'd0 || bus_if.ser_rst !== 1'b1 ||
          bus_if.done !== 1'b0 || bus_if.ser_a !== 1'b0) begin
         n_err++;
         $display("FAIL midrst ready=%b sum=%0d ser_rst=%b done=%b ser_a=%b exp 1 0 1 0 0",
                  bus_if.ready, bus_if.sum, bus_if.ser_rst, bus_if.done, bus_if.ser_a);
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (bus_if.done === 1'b1) ndone++;
      end
      rst = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus_if.done === 1'b1) ndone++;
      end
      n_vec++;
      if (ndone != 0 || bus_if.sum !== 5'd0) begin
         n_err++;
         $display("FAIL midrst_nodone dones=%0d sum=%0d exp 0 0", ndone, bus_if.sum);
      end
      run_op(4'd9, 4'd6, s, lat, rdy, t);
      n_vec++;
      if (s !== 5'd15 || lat != LAT) begin
         n_err++;
         $display("FAIL midrst_after sum=%0d lat=%0d exp 15 %0d", s, lat, LAT);
      end
   endtask

   task automatic test_back_to_back();
      logic [N:0] s1;
      logic [N:0] s2;
      int lat1;
      int lat2;
      int t1;
      int t2;
      logic r1;
      logic r2;
      run_op(4'd7, 4'd8, s1, lat1, r1, t1);
      run_op(4'd1, 4'd1, s2, lat2, r2, t2);
      n_vec++;
      if (s1 !== 5'd15 || s2 !== 5'd2) begin
         n_err++;
         $display("FAIL b2b_sums got %0d %0d exp 15 2", s1, s2);
      end
      n_vec++;
      if (r2 !== 1'b1 || lat1 < 0 || lat2 < 0 || (t2 - t1) != int'(N + 3)) begin
         n_err++;
         $display("FAIL b2b_timing ready=%b gap=%0d exp 1 %0d", r2, t2 - t1, N + 3);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      cyc = 0;
      test_reset();
      test_basic();
      test_corners();
      test_exhaustive();
      test_hold_start();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
